rs_dispatch_ctrl: RTL
=====================

// Module: rs_dispatch_ctrl
// PURPOSE
//  Credit-based dispatch controller in front of the reservation station (RS).
//  Tracks free RS entries and gates rename->RS allocation so the RS never overflows.
//  Sequences a pipeline flush: clears the RS and holds dispatch off during recovery.
//  Sits between the rename/dispatch stage and the RS alloc_en inputs.
// PARAMETERS
//  RS_ENTRIES    16  RS capacity (credit pool size)
//  ISSUE_W       2   dispatch/issue lanes (same value as the RS)
//  FLUSH_CYCLES  2   recovery cycles after the flush pulse; must be >=1
//  CNT_W  $clog2(RS_ENTRIES+1)  credit counter width (localparam)
// PORTS
//  clk            in   1           core clock
//  reset          in   1           async, active-high
//  disp_valid     in   ISSUE_W     rename has uop on lane k
//  disp_ready     out  ISSUE_W     lane k accepted this cycle if also valid
//  rs_alloc_en    out  ISSUE_W     to RS alloc_en; = disp_valid & disp_ready
//  rs_issue_valid in   ISSUE_W     RS issue_valid; each bit returns one credit
//  flush_req      in   1           mispredict/exception flush request
//  rs_flush       out  1           one-cycle RS clear pulse
//  free_count     out  CNT_W       registered free-credit count
//  rs_full        out  1           free_count==0
//  rs_empty       out  1           free_count==RS_ENTRIES
//  stall_cycles   out  32          saturating dispatch-stall perf counter
//  credit_err     out  1           sticky: credit overflow detected
// BEHAVIOUR
//  Reset (async): state=RUN, free_count=RS_ENTRIES, rec_cnt=0, stall_cycles=0,
//   credit_err=0, rs_flush=0. disp_ready/rs_alloc_en follow combinationally.
//  FSM states:
//   RUN: normal dispatch.
//   FLUSH: rs_flush=1 for exactly this cycle. No dispatch. Credits forced to RS_ENTRIES.
//   RECOVER: no dispatch for FLUSH_CYCLES cycles. Credit returns are ignored.
//  Transitions:
//   any state + flush_req -> FLUSH. Flush has priority over all other events.
//   FLUSH -> RECOVER, with rec_cnt=FLUSH_CYCLES-1.
//   RECOVER -> RUN when rec_cnt==0; otherwise rec_cnt decrements.
//  Lane readiness (combinational, in-order):
//   disp_ready[k] = (state==RUN) & !flush_req & (free_count >= k+1) & &disp_valid[k-1:0].
//   A lane is never accepted past an invalid lower lane (no holes).
//   Credits returned in a cycle are not usable until the next cycle (no bypass).
//  Credit update (RUN only):
//   free_next = free_count - popcount(rs_alloc_en) + popcount(rs_issue_valid).
//   Same-cycle alloc and return are both applied.
//   If free_next > RS_ENTRIES: clamp to RS_ENTRIES and set credit_err.
//   credit_err clears only on reset.
//   Underflow is impossible by construction, because acceptance is bounded by free_count.
//  free_count, rs_full and rs_empty are registered values; they update 1 cycle after the event.
//  stall_cycles: +1 each cycle in which any disp_valid[k] & !disp_ready[k] holds.
//   This includes the FLUSH and RECOVER states. It saturates at 32'hFFFF_FFFF.
//  Reset mid-flush: returns immediately to the RUN/full-credit reset state and rs_flush drops.
//  flush_req held high: the block remains in FLUSH and rs_flush stays high every cycle.
// TESTING
//  Reset, then disp_valid=2'b11 every cycle, no issues:
//   8 cycles each allocate 2 entries; free_count reaches 0; rs_full=1; disp_ready=00.
//  free_count=1 with disp_valid=11: only lane 0 accepted (rs_alloc_en=01).
//   Next cycle free_count=0.
//  disp_valid=10 with free_count=5: disp_ready[1]=0 and rs_alloc_en=00 (in-order rule).
//  free_count=0 with rs_issue_valid=11: disp_ready stays 00 in the same cycle;
//   the next cycle has free_count=2 and both lanes accepted.
//  flush_req pulse at free_count=3:
//   rs_flush=1 for 1 cycle; disp_ready=0 for 1+FLUSH_CYCLES=3 cycles;
//   free_count=16 afterwards; dispatch resumes.
//  Return 1 credit while free_count=16: credit_err=1 (sticky), free_count stays 16.
//  Assert reset mid-RECOVER: state is RUN and free_count=16 on the next edge.

Source files
------------

// File: rtl/rs_dispatch_if.sv
// rtl/rs_dispatch_if.sv - dispatch/RS handshake bundle for the RS credit controller
interface rs_dispatch_if #(
  parameter int ISSUE_W = 2
);
  logic [ISSUE_W-1:0] disp_valid;
  logic [ISSUE_W-1:0] disp_ready;
  logic [ISSUE_W-1:0] rs_alloc_en;
  logic [ISSUE_W-1:0] rs_issue_valid;
  logic               flush_req;
  logic               rs_flush;

  modport master (
    output disp_valid,
    output rs_issue_valid,
    output flush_req,
    input  disp_ready,
    input  rs_alloc_en,
    input  rs_flush
  );

  modport slave (
    input  disp_valid,
    input  rs_issue_valid,
    input  flush_req,
    output disp_ready,
    output rs_alloc_en,
    output rs_flush
  );
endinterface

// File: rtl/rs_dispatch_ctrl.sv
// rtl/rs_dispatch_ctrl.sv - credit-based rename->RS dispatch gate with flush/recovery sequencing
module rs_dispatch_ctrl #(
  parameter int  RS_ENTRIES   = 16,
  parameter int  ISSUE_W      = 2,
  parameter int  FLUSH_CYCLES = 2,
  localparam int CNT_W        = $clog2(RS_ENTRIES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  rs_dispatch_if.slave     disp,
  output logic [CNT_W-1:0] free_count,
  output logic             rs_full,
  output logic             rs_empty,
  output logic [31:0]      stall_cycles,
  output logic             credit_err
);

  localparam int REC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_FLUSH   = 2'd1;
  localparam logic [1:0] ST_RECOVER = 2'd2;

  logic [1:0]         state;
  logic [REC_W-1:0]   rec_cnt;
  logic [ISSUE_W-1:0] ready;
  logic [ISSUE_W-1:0] alloc;
  logic [CNT_W:0]     free_sum;
  logic               credit_ovf;
  logic               stall_now;

  function automatic logic [CNT_W:0] popcnt(input logic [ISSUE_W-1:0] v);
    logic [CNT_W:0] n;
    n = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      n = n + (CNT_W+1)'(v[i]);
    end
    return n;
  endfunction

  // In-order acceptance: lane k needs k+1 credits and every lower lane valid.
  always_comb begin
    logic run_ok;
    logic lower_ok;
    ready    = '0;
    run_ok   = (state == ST_RUN) && !disp.flush_req;
    lower_ok = 1'b1;
    for (int k = 0; k < ISSUE_W; k++) begin
      ready[k] = run_ok && lower_ok && ({1'b0, free_count} > (CNT_W+1)'(k));
      lower_ok = lower_ok & disp.disp_valid[k];
    end
  end

  assign alloc            = disp.disp_valid & ready;
  assign disp.disp_ready  = ready;
  assign disp.rs_alloc_en = alloc;
  assign disp.rs_flush    = (state == ST_FLUSH);

  assign free_sum   = {1'b0, free_count} - popcnt(alloc) + popcnt(disp.rs_issue_valid);
  assign credit_ovf = free_sum > (CNT_W+1)'(RS_ENTRIES);
  assign stall_now  = |(disp.disp_valid & ~ready);

  assign rs_full  = (free_count == '0);
  assign rs_empty = (free_count == CNT_W'(RS_ENTRIES));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_RUN;
      rec_cnt      <= '0;
      free_count   <= CNT_W'(RS_ENTRIES);
      stall_cycles <= '0;
      credit_err   <= 1'b0;
    end else begin
      if (stall_now && (stall_cycles != 32'hFFFF_FFFF)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (state == ST_FLUSH) begin
        free_count <= CNT_W'(RS_ENTRIES);
      end
      if (disp.flush_req) begin
        state <= ST_FLUSH;
      end else begin
        case (state)
          ST_RUN: begin
            if (credit_ovf) begin
              free_count <= CNT_W'(RS_ENTRIES);
              credit_err <= 1'b1;
            end else begin
              free_count <= free_sum[CNT_W-1:0];
            end
          end
          ST_FLUSH: begin
            state   <= ST_RECOVER;
            rec_cnt <= REC_W'(FLUSH_CYCLES - 1);
          end
          ST_RECOVER: begin
            // Credit returns here belong to squashed uops and are dropped.
            if (rec_cnt == '0) begin
              state <= ST_RUN;
            end else begin
              rec_cnt <= rec_cnt - 1'b1;
            end
          end
          default: state <= ST_RUN;
        endcase
      end
    end
  end

endmodule
